// File: rtl/clock_pkg.sv
// Shared definitions for the clock timekeeping slice: mode encodings,
// digit widths and limits, and the nonuniform hour increment.
package clock_pkg;

  typedef enum logic [1:0] {
    MODE_RUN     = 2'b00,
    MODE_SET_HR  = 2'b01,
    MODE_SET_MIN = 2'b10
  } mode_t;

  localparam int SEC_LO_W = 4;
  localparam int SEC_HI_W = 3;
  localparam int MIN_LO_W = 4;
  localparam int MIN_HI_W = 3;
  localparam int HR_LO_W  = 4;
  localparam int HR_HI_W  = 2;

  localparam int SEC_LO_MAX = 9;
  localparam int SEC_HI_MAX = 5;
  localparam int MIN_LO_MAX = 9;
  localparam int MIN_HI_MAX = 5;

  localparam int HR_MAX_DEFAULT = 23;

  // Hours wrap at an arbitrary two-digit value, so the pair cannot be two
  // independent modulo counters; returns {hr_hi, hr_lo} after one increment.
  function automatic logic [5:0] next_hour(input logic [1:0] hi,
                                           input logic [3:0] lo,
                                           input int hr_max);
    logic [1:0] max_hi;
    logic [3:0] max_lo;
    max_hi = 2'(hr_max / 10);
    max_lo = 4'(hr_max % 10);
    if (hi == max_hi && lo == max_lo)
      return 6'd0;
    else if (lo == 4'd9)
      return {hi + 2'd1, 4'd0};
    else
      return {hi, lo + 4'd1};
  endfunction

endpackage

// File: rtl/clock_ctrl_if.sv
// Control inputs and displayed time/status outputs of the clock sequencer.
interface clock_ctrl_if;
  import clock_pkg::*;

  logic                ena;
  logic                tick;
  logic                btn_mode;
  logic                btn_inc;
  logic [SEC_LO_W-1:0] sec_lo;
  logic [SEC_HI_W-1:0] sec_hi;
  logic [MIN_LO_W-1:0] min_lo;
  logic [MIN_HI_W-1:0] min_hi;
  logic [HR_LO_W-1:0]  hr_lo;
  logic [HR_HI_W-1:0]  hr_hi;
  logic [1:0]          mode;
  logic                blink;

  modport master (
    output ena, tick, btn_mode, btn_inc,
    input  sec_lo, sec_hi, min_lo, min_hi, hr_lo, hr_hi, mode, blink
  );

  modport slave (
    input  ena, tick, btn_mode, btn_inc,
    output sec_lo, sec_hi, min_lo, min_hi, hr_lo, hr_hi, mode, blink
  );

endinterface

// File: rtl/digit_counter.sv
// Single BCD-style digit counting 0..MOD-1 with synchronous clear and a
// combinational carry raised on the increment that wraps it.
module digit_counter #(
  parameter int MOD   = 10,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             res,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt,
  output logic             carry
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MOD - 1);

  assign carry = inc & (cnt == LAST);

  always_ff @(posedge clk or negedge res) begin
    if (!res)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (inc)
      cnt <= carry ? '0 : cnt + WIDTH'(1);
  end

endmodule

// File: rtl/clock_ctrl.sv
// Timekeeping sequencer: 1 Hz tick drives the ss/mm/hh cascade, and a
// three-state button FSM lets the user set hours and minutes.
module clock_ctrl
  import clock_pkg::*;
#(
  parameter int HR_MAX      = HR_MAX_DEFAULT,
  parameter int SET_CLR_SEC = 1
) (
  input logic         clk,
  input logic         res,
  clock_ctrl_if.slave bus
);

  mode_t state_q, state_d;
  logic  blink_q, blink_d;
  logic  btn_mode_q, btn_inc_q;
  logic  rise_mode, rise_inc;
  logic  in_run, in_set_hr, in_set_min;

  logic  sec_lo_inc, sec_lo_carry, sec_hi_carry, sec_clr;
  logic  min_lo_inc, min_lo_carry, min_hi_carry;
  logic  hr_inc;

  logic [SEC_LO_W-1:0] sec_lo;
  logic [SEC_HI_W-1:0] sec_hi;
  logic [MIN_LO_W-1:0] min_lo;
  logic [MIN_HI_W-1:0] min_hi;
  logic [HR_LO_W-1:0]  hr_lo;
  logic [HR_HI_W-1:0]  hr_hi;

  // Button history tracks every clock regardless of ena, so a button held
  // through a disabled period does not look like a fresh press afterwards.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      btn_mode_q <= 1'b0;
      btn_inc_q  <= 1'b0;
    end else begin
      btn_mode_q <= bus.btn_mode;
      btn_inc_q  <= bus.btn_inc;
    end
  end

  assign rise_mode = bus.btn_mode & ~btn_mode_q;
  assign rise_inc  = bus.btn_inc & ~btn_inc_q;

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q <= MODE_RUN;
      blink_q <= 1'b0;
    end else begin
      state_q <= state_d;
      blink_q <= blink_d;
    end
  end

  always_comb begin
    state_d = state_q;
    blink_d = blink_q;
    if (bus.ena) begin
      case (state_q)
        MODE_RUN: begin
          blink_d = 1'b0;
          if (rise_mode) state_d = MODE_SET_HR;
        end
        MODE_SET_HR: begin
          if (bus.tick) blink_d = ~blink_q;
          if (rise_mode) state_d = MODE_SET_MIN;
        end
        MODE_SET_MIN: begin
          if (bus.tick) blink_d = ~blink_q;
          if (rise_mode) begin
            state_d = MODE_RUN;
            blink_d = 1'b0;
          end
        end
        default: begin
          state_d = MODE_RUN;
          blink_d = 1'b0;
        end
      endcase
    end
  end

  assign in_run     = (state_q == MODE_RUN);
  assign in_set_hr  = (state_q == MODE_SET_HR);
  assign in_set_min = (state_q == MODE_SET_MIN);

  // In set modes the cascade is cut at the digit being edited, so wrapping a
  // minute or hour never disturbs the neighbouring field.
  assign sec_lo_inc = bus.ena & in_run & bus.tick;
  assign sec_clr    = bus.ena & in_set_min & rise_mode & (SET_CLR_SEC != 0);
  assign min_lo_inc = in_run ? sec_hi_carry
                             : (bus.ena & in_set_min & rise_inc & ~rise_mode);
  assign hr_inc     = in_run ? min_hi_carry
                             : (bus.ena & in_set_hr & rise_inc & ~rise_mode);

  digit_counter #(.MOD(SEC_LO_MAX + 1), .WIDTH(SEC_LO_W)) u_sec_lo (
    .clk(clk), .res(res), .inc(sec_lo_inc), .clr(sec_clr),
    .cnt(sec_lo), .carry(sec_lo_carry)
  );

  digit_counter #(.MOD(SEC_HI_MAX + 1), .WIDTH(SEC_HI_W)) u_sec_hi (
    .clk(clk), .res(res), .inc(sec_lo_carry), .clr(sec_clr),
    .cnt(sec_hi), .carry(sec_hi_carry)
  );

  digit_counter #(.MOD(MIN_LO_MAX + 1), .WIDTH(MIN_LO_W)) u_min_lo (
    .clk(clk), .res(res), .inc(min_lo_inc), .clr(1'b0),
    .cnt(min_lo), .carry(min_lo_carry)
  );

  digit_counter #(.MOD(MIN_HI_MAX + 1), .WIDTH(MIN_HI_W)) u_min_hi (
    .clk(clk), .res(res), .inc(min_lo_carry), .clr(1'b0),
    .cnt(min_hi), .carry(min_hi_carry)
  );

  always_ff @(posedge clk or negedge res) begin
    if (!res)
      {hr_hi, hr_lo} <= '0;
    else if (hr_inc)
      {hr_hi, hr_lo} <= next_hour(hr_hi, hr_lo, HR_MAX);
  end

  assign bus.sec_lo = sec_lo;
  assign bus.sec_hi = sec_hi;
  assign bus.min_lo = min_lo;
  assign bus.min_hi = min_hi;
  assign bus.hr_lo  = hr_lo;
  assign bus.hr_hi  = hr_hi;
  assign bus.mode   = state_q;
  assign bus.blink  = blink_q;

endmodule

// File: tb/tb_clock_ctrl.sv
// Self-checking bench for clock_ctrl: an integer reference model predicts
// time/mode/blink per cycle into a scoreboard checked one cycle later.
module tb_clock_ctrl;

  localparam int HR_MAX = 23;

  typedef struct {
    int hhmmss;
    int mode;
    int blink;
  } exp_t;

  logic clk = 1'b0;
  logic res = 1'b0;

  clock_ctrl_if bus();

  clock_ctrl #(.HR_MAX(HR_MAX), .SET_CLR_SEC(1)) dut (
    .clk(clk),
    .res(res),
    .bus(bus)
  );

  always #5 clk = ~clk;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  int m_hh, m_mm, m_ss, m_mode, m_blink, m_bmq, m_biq;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    m_hh = 0; m_mm = 0; m_ss = 0;
    m_mode = 0; m_blink = 0; m_bmq = 0; m_biq = 0;
  endtask

  task automatic modelStep(input int ena, input int tick, input int bm, input int bi);
    int rm, ri;
    rm = bm & ~m_bmq & 1;
    ri = bi & ~m_biq & 1;
    m_bmq = bm;
    m_biq = bi;
    if (ena != 0) begin
      case (m_mode)
        0: begin
          if (tick != 0) begin
            m_ss++;
            if (m_ss == 60) begin
              m_ss = 0;
              m_mm++;
              if (m_mm == 60) begin
                m_mm = 0;
                m_hh = (m_hh == HR_MAX) ? 0 : m_hh + 1;
              end
            end
          end
          m_blink = 0;
          if (rm != 0) m_mode = 1;
        end
        1: begin
          if (tick != 0) m_blink ^= 1;
          if (rm != 0) m_mode = 2;
          else if (ri != 0) m_hh = (m_hh == HR_MAX) ? 0 : m_hh + 1;
        end
        default: begin
          if (tick != 0) m_blink ^= 1;
          if (rm != 0) begin
            m_mode = 0;
            m_ss = 0;
            m_blink = 0;
          end else if (ri != 0) begin
            m_mm = (m_mm + 1) % 60;
          end
        end
      endcase
    end
  endtask

  function automatic exp_t modelSnapshot();
    exp_t e;
    e.hhmmss = m_hh * 10000 + m_mm * 100 + m_ss;
    e.mode   = m_mode;
    e.blink  = m_blink;
    return e;
  endfunction

  task automatic checkScoreboard(input string tag);
    exp_t e;
    int   obs_time;
    if (sb_q.size() == 0) begin
      checkOutput({tag, "_sb_empty"}, 0, 1);
      return;
    end
    e = sb_q.pop_front();
    obs_time = (int'(bus.hr_hi) * 10 + int'(bus.hr_lo)) * 10000
             + (int'(bus.min_hi) * 10 + int'(bus.min_lo)) * 100
             + (int'(bus.sec_hi) * 10 + int'(bus.sec_lo));
    checkOutput({tag, "_time"}, obs_time, e.hhmmss);
    checkOutput({tag, "_mode"}, int'(bus.mode), e.mode);
    checkOutput({tag, "_blink"}, int'(bus.blink), e.blink);
  endtask

  task automatic applyStimulus(input string tag, input logic ena, input logic tick,
                               input logic bm, input logic bi);
    @(negedge clk);
    bus.ena      = ena;
    bus.tick     = tick;
    bus.btn_mode = bm;
    bus.btn_inc  = bi;
    modelStep(int'(ena), int'(tick), int'(bm), int'(bi));
    sb_q.push_back(modelSnapshot());
    @(posedge clk);
    #1;
    checkScoreboard(tag);
  endtask

  task automatic pressInc(input string tag);
    applyStimulus(tag, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(tag, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pressMode(input string tag);
    applyStimulus(tag, 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(tag, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tickOnce(input string tag);
    applyStimulus(tag, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic asyncReset(input string tag);
    @(negedge clk);
    #2;
    bus.ena = 1'b0; bus.tick = 1'b0; bus.btn_mode = 1'b0; bus.btn_inc = 1'b0;
    res = 1'b0;
    modelReset();
    sb_q.push_back(modelSnapshot());
    #1;
    checkScoreboard(tag);
    @(negedge clk);
    res = 1'b1;
  endtask

  initial begin
    bus.ena = 1'b0; bus.tick = 1'b0; bus.btn_mode = 1'b0; bus.btn_inc = 1'b0;
    modelReset();
    #12;
    sb_q.push_back(modelSnapshot());
    checkScoreboard("por");
    @(negedge clk);
    res = 1'b1;

    // Count a little, confirm btn_inc is ignored in RUN, then reset mid-count.
    repeat (7) tickOnce("run");
    applyStimulus("run_inc_ignored", 1'b1, 1'b1, 1'b0, 1'b1);
    applyStimulus("run_idle", 1'b1, 1'b0, 1'b0, 1'b0);
    asyncReset("mid_reset");
    applyStimulus("post_reset", 1'b1, 1'b0, 1'b0, 1'b0);

    // Preload 23:59:58 through the set modes, then cross midnight.
    pressMode("to_set_hr");
    for (int i = 0; i < 23; i++) pressInc("load_hr");
    pressMode("to_set_min");
    for (int i = 0; i < 59; i++) pressInc("load_min");
    pressMode("to_run");
    for (int i = 0; i < 58; i++) tickOnce("load_sec");
    tickOnce("wrap_235959");
    tickOnce("wrap_000000");

    // Tick and mode press together in RUN: both take effect.
    applyStimulus("tick_and_mode", 1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus("tick_and_mode_rel", 1'b1, 1'b0, 1'b0, 1'b0);

    // Hour wrap in SET_HR without carry, then blink on ticks.
    for (int i = 0; i < 24; i++) pressInc("set_hr_wrap");
    for (int i = 0; i < 3; i++) tickOnce("set_hr_blink");

    // Mode and inc together: mode wins, hour untouched.
    applyStimulus("mode_beats_inc", 1'b1, 1'b0, 1'b1, 1'b1);
    applyStimulus("mode_beats_inc_rel", 1'b1, 1'b0, 1'b0, 1'b0);

    // Tick and inc together in SET_MIN: both apply.
    applyStimulus("tick_and_inc", 1'b1, 1'b1, 1'b0, 1'b1);
    applyStimulus("tick_and_inc_rel", 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 58; i++) pressInc("load_min59");
    pressMode("set_min_exit");
    for (int i = 0; i < 42; i++) tickOnce("to_sec42");

    // Minute wrap at 59 with no carry into hours, then exit clears seconds.
    pressMode("sec42_set_hr");
    pressMode("sec42_set_min");
    tickOnce("sec42_blink");
    pressInc("min_wrap");
    pressMode("exit_clr_sec");

    // Held btn_inc across ena 0->1 must not increment.
    pressMode("ena_set_hr");
    applyStimulus("ena_off_inc", 1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus("ena_on_held", 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus("ena_on_rel", 1'b1, 1'b0, 1'b0, 1'b0);
    pressMode("ena_set_min");
    pressMode("ena_run");

    // Frozen while disabled, including a lost mode press held across enable.
    for (int i = 0; i < 5; i++) applyStimulus("frozen_tick", 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus("frozen_mode", 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus("mode_held", 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus("mode_held_rel", 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tickOnce("resume");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
